// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Samples the raw PS/2 lines in the clk domain and checks each 11-bit frame:
// start, 8 data bits LSB-first, odd parity, stop. Good bytes go into a small
// FIFO that the consumer drains with a ready / nextdata_n pop handshake.
// Framing faults pulse frame_err for one cycle. A watchdog abandons frames
// that stop clocking partway through.
module ps2_frame_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchronisers and falling-edge detection
  // ---------------------------------------------------------------------------
  logic ps2_clk_s1, ps2_clk_s2, ps2_clk_d;
  logic ps2_data_s1, ps2_data_s2;
  logic fall;
  logic bit_in;

  // Two-flop synchronisers plus one extra clock stage for edge detection;
  // preset to 1 so a reset never looks like a falling edge on an idle bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2_clk_s1  <= 1'b1;
      ps2_clk_s2  <= 1'b1;
      ps2_clk_d   <= 1'b1;
      ps2_data_s1 <= 1'b1;
      ps2_data_s2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the old value of
      // its predecessor, which is what makes this a shift chain.
      ps2_clk_s1  <= ps2_clk;
      ps2_clk_s2  <= ps2_clk_s1;
      ps2_clk_d   <= ps2_clk_s2;
      ps2_data_s1 <= ps2_data;
      ps2_data_s2 <= ps2_data_s1;
    end
  end

  assign fall   = ps2_clk_d & ~ps2_clk_s2;
  assign bit_in = ps2_data_s2;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_t          state, state_next;
  logic [9:0]      shreg;
  logic [3:0]      bitcnt;
  logic [WD_W-1:0] wdog;
  logic            push_req;
  logic            err_now;
  logic            timeout;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the single-cycle push and error strobes.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_next = state;
    push_req   = 1'b0;
    err_now    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          if (!bit_in) begin
            state_next = RECV;
          end else begin
            err_now = 1'b1;
          end
        end
      end
      RECV: begin
        if (fall) begin
          if (bitcnt == LAST_BIT) begin
            state_next = CHECK;
          end
        end else if (wdog == WD_LAST) begin
          err_now    = 1'b1;
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      CHECK: begin
        state_next = IDLE;
        // Odd parity across data+parity, and a high stop bit.
        if ((^shreg[8:0]) && shreg[9]) begin
          push_req = 1'b1;
        end else begin
          err_now = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shift register, bit counter and watchdog. Bits enter at the top and move
  // down, so after ten shifts [7:0] is the byte, [8] parity, [9] stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg  <= '0;
      bitcnt <= '0;
      wdog   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog   <= '0;
          bitcnt <= (fall && !bit_in) ? 4'd1 : 4'd0;
        end
        RECV: begin
          if (fall) begin
            shreg  <= {bit_in, shreg[9:1]};
            bitcnt <= bitcnt + 4'd1;
            wdog   <= '0;
          end else if (timeout) begin
            bitcnt <= '0;
            wdog   <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: begin
          wdog <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, rptr_next;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;

  assign pop       = ready & ~nextdata_n;
  assign full      = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is still accepted then.
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign rptr_next = pop ? rptr + 1'b1 : rptr;

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, and leaving it unreset keeps it a plain RAM.
    if (push_ok) begin
      mem[wptr[AW-1:0]] <= shreg[7:0];
    end
  end

  // Pointers and registered consumer-side outputs. data/ready look at the
  // post-pop read pointer so a pop is reflected in the very next cycle and
  // ready is never left stale-high after the last entry leaves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr      <= '0;
      rptr      <= '0;
      data      <= 8'h00;
      ready     <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      rptr      <= rptr_next;
      ready     <= (wptr != rptr_next);
      data      <= mem[rptr_next[AW-1:0]];
      frame_err <= err_now;
      // Set has priority over the clear from an accepted pop.
      if (drop) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed testbench for ps2_frame_rx: a table of single frames with
// hand-computed results, followed by hand-written multi-frame sequences for
// overflow, pop-during-push, watchdog timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_ps2_frame_rx;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 200;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_frame_rx #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Free-running cycle counter and an output monitor sampled on the falling
  // clock edge, away from the active edge.
  int   cyc = 0;
  int   err_pulses = 0;
  int   last_err_cyc = 0;
  int   ready_rise_cyc = 0;
  logic ready_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      err_pulses++;
      last_err_cyc = cyc;
    end
    if (ready === 1'b1 && ready_prev !== 1'b1) ready_rise_cyc = cyc;
    ready_prev = ready;
  end

  int stop_cyc = 0;
  int edge_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // One PS/2 bit cell: data changes mid-high, clock low 20 clk, high 20 clk.
  // Returns right after the cell ends with ps2_clk high.
  task automatic ps2_bit(input logic b, input logic is_stop, input logic pop_at_check);
    ps2_data = b;
    repeat (10) tick();
    ps2_clk  = 1'b0;
    edge_cyc = cyc;
    if (is_stop) stop_cyc = cyc;
    if (pop_at_check) begin
      // Edge reaches the FSM after the 2-FF sync; CHECK is the 4th cycle.
      repeat (3) tick();
      nextdata_n = 1'b0;
      tick();
      nextdata_n = 1'b1;
      repeat (16) tick();
    end else begin
      repeat (20) tick();
    end
    ps2_clk = 1'b1;
    repeat (10) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic pop_at_check);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_bit(bits[i], i == 10, (i == 10) && pop_at_check);
    end
    ps2_data = 1'b1;
    repeat (10) tick();
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, odd_par(d), 1'b1, 1'b0);
  endtask

  // Only the first n bits of a frame carrying d, then the bus goes idle-high.
  task automatic send_partial(input logic [7:0] d, input int n);
    logic [10:0] bits;
    bits = {1'b1, odd_par(d), d, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_bit(bits[i], 1'b0, 1'b0);
    end
    ps2_data = 1'b1;
  endtask

  task automatic pop_one();
    nextdata_n = 1'b0;
    tick();
    nextdata_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    int         exp_err;
    logic       exp_ready;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[10];
  int   err0;
  int   lat;

  initial begin
    //          d      par   stop  err ready data
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 0, 1'b1, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1, 1'b0, 8'h00};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 0, 1'b1, 8'hF0};
    vecs[3] = '{8'h1C, 1'b0, 1'b0, 1, 1'b0, 8'h00};
    vecs[4] = '{8'h5A, 1'b1, 1'b1, 0, 1'b1, 8'h5A};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h00};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 0, 1'b1, 8'hFF};
    vecs[7] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 8'h00};
    vecs[8] = '{8'h80, 1'b0, 1'b1, 0, 1'b1, 8'h80};
    vecs[9] = '{8'h29, 1'b0, 1'b1, 0, 1'b1, 8'h29};

    rst        = 1'b0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) tick();

    // Reset state.
    check("rst_ready", ready, 1'b0);
    check("rst_data", data, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b1;
    tick();

    // A pop request on an empty FIFO must not move the read pointer.
    nextdata_n = 1'b0;
    repeat (4) tick();
    nextdata_n = 1'b1;
    tick();
    check("empty_pop_ready", ready, 1'b0);

    // Table of single frames; the FIFO is drained after each one.
    for (int i = 0; i < 10; i++) begin
      err0 = err_pulses;
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, 1'b0);
      check($sformatf("v%0d_err_pulses", i), err_pulses - err0, vecs[i].exp_err);
      check($sformatf("v%0d_ready", i), ready, vecs[i].exp_ready);
      if (vecs[i].exp_ready) begin
        check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
        check_range($sformatf("v%0d_ready_latency", i), ready_rise_cyc - stop_cyc, 1, 6);
        pop_one();
        check($sformatf("v%0d_ready_after_pop", i), ready, 1'b0);
      end
    end

    // A lone falling edge with data high is a bad start bit.
    err0 = err_pulses;
    ps2_bit(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    check("bad_start_err_pulses", err_pulses - err0, 1);
    check("bad_start_ready", ready, 1'b0);

    // Overflow: nine frames into an eight-entry FIFO.
    for (int i = 1; i <= 9; i++) send_good(8'(i));
    check("ovf_set", overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_pop%0d_ready", i), ready, 1'b1);
      check($sformatf("ovf_pop%0d_data", i), data, 8'(i));
      pop_one();
      if (i == 1) check("ovf_clear_after_pop", overflow, 1'b0);
    end
    check("ovf_drained_ready", ready, 1'b0);

    // Watchdog: start bit plus four data bits, then the clock stops.
    err0 = err_pulses;
    send_partial(8'hA5, 5);
    repeat (260) tick();
    check("timeout_err_pulses", err_pulses - err0, 1);
    check_range("timeout_latency", last_err_cyc - edge_cyc, 200, 206);
    check("timeout_ready", ready, 1'b0);
    err0 = err_pulses;
    send_good(8'h5A);
    check("post_timeout_err", err_pulses - err0, 0);
    check("post_timeout_ready", ready, 1'b1);
    check("post_timeout_data", data, 8'h5A);
    pop_one();

    // Full FIFO with a pop in the CHECK cycle of the ninth frame.
    for (int i = 0; i < 8; i++) send_good(8'h10 + 8'(i));
    send_frame(8'h77, odd_par(8'h77), 1'b1, 1'b1);
    check("full_pop_overflow", overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_pop%0d_ready", i), ready, 1'b1);
      check($sformatf("full_pop%0d_data", i), data, (i < 7) ? 8'h11 + 8'(i) : 8'h77);
      pop_one();
    end
    check("full_pop_drained", ready, 1'b0);

    // Asynchronous reset in the middle of a frame with bytes buffered.
    send_good(8'h31);
    send_good(8'h32);
    send_good(8'h33);
    check("pre_rst_ready", ready, 1'b1);
    send_partial(8'h44, 6);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", ready, 1'b0);
    check("mid_rst_data", data, 8'h00);
    check("mid_rst_overflow", overflow, 1'b0);
    tick();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) tick();
    rst  = 1'b1;
    err0 = err_pulses;
    repeat (300) tick();
    check("post_rst_idle_err", err_pulses - err0, 0);
    check("post_rst_idle_ready", ready, 1'b0);
    send_good(8'h29);
    check("post_rst_ready", ready, 1'b1);
    check("post_rst_data", data, 8'h29);
    check("post_rst_err", err_pulses - err0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
